// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, two-entry skid buffer,
// synchronous flush. Control bits read as zero whenever an entry is invalid.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    logic              head_valid_r;
    logic [DATA_W-1:0] head_data_r;
    logic [CTRL_W-1:0] head_ctrl_r;
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic              accept_s;
    logic              release_s;

    // Ready depends only on the registered skid state, gated by squash/reset.
    assign in_ready  = !skid_valid_r && !flush && !reset;
    assign accept_s  = in_valid && in_ready;
    assign release_s = head_valid_r && out_ready;

    assign out_valid = head_valid_r;
    assign out_data  = head_data_r;
    assign out_ctrl  = head_ctrl_r;
    assign count     = {skid_valid_r, head_valid_r & ~skid_valid_r};

    // Head/skid storage update: reset, then flush, then accept/release.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid_r <= 1'b0;
            head_data_r  <= {DATA_W{1'b0}};
            head_ctrl_r  <= {CTRL_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
            skid_ctrl_r  <= {CTRL_W{1'b0}};
        end else if (flush) begin
            // Payloads are kept; only validity and control are squashed.
            head_valid_r <= 1'b0;
            head_ctrl_r  <= {CTRL_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_ctrl_r  <= {CTRL_W{1'b0}};
        end else begin
            case ({skid_valid_r, head_valid_r})
                2'b00: begin
                    if (accept_s) begin
                        head_valid_r <= 1'b1;
                        head_data_r  <= in_data;
                        head_ctrl_r  <= in_ctrl;
                    end
                end
                2'b01: begin
                    if (accept_s && release_s) begin
                        head_data_r  <= in_data;
                        head_ctrl_r  <= in_ctrl;
                    end else if (accept_s) begin
                        skid_valid_r <= 1'b1;
                        skid_data_r  <= in_data;
                        skid_ctrl_r  <= in_ctrl;
                    end else if (release_s) begin
                        head_valid_r <= 1'b0;
                        head_ctrl_r  <= {CTRL_W{1'b0}};
                    end
                end
                2'b11: begin
                    if (release_s) begin
                        head_data_r  <= skid_data_r;
                        head_ctrl_r  <= skid_ctrl_r;
                        skid_valid_r <= 1'b0;
                        skid_ctrl_r  <= {CTRL_W{1'b0}};
                    end
                end
                default: begin
                    // Skid valid without head valid cannot occur; drop to empty.
                    head_valid_r <= 1'b0;
                    head_ctrl_r  <= {CTRL_W{1'b0}};
                    skid_valid_r <= 1'b0;
                    skid_ctrl_r  <= {CTRL_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  c;
    } ent_t;

    ent_t        q[$];
    logic [31:0] last_data;
    bit          mdl_acc;
    bit          chk_en = 1'b0;
    logic [31:0] rel_log[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .count(count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries; head payload lingers after it leaves.
    always @(posedge clk) begin
        bit   acc, rel;
        ent_t e;
        acc = in_valid && (q.size() < 2) && !flush && !reset;
        rel = (q.size() > 0) && out_ready;
        if (!reset && out_valid && out_ready) rel_log.push_back(out_data);
        if (reset) begin
            q.delete();
            last_data = 32'h0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (rel) void'(q.pop_front());
            if (acc) begin
                e.d = in_data;
                e.c = in_ctrl;
                q.push_back(e);
            end
        end
        if (q.size() > 0) last_data = q[0].d;
        mdl_acc = acc;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("out_data", out_data, last_data);
            chk("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : 8'h00);
            chk("count", count, q.size());
            chk("in_ready", in_ready, (q.size() < 2) && !flush && !reset);
        end
    end

    task automatic step(input bit v, input logic [31:0] d, input logic [7:0] c,
                        input bit ordy, input bit fl, input bit rs);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 32'h0; in_ctrl = 8'h0;

        // Reset with a beat offered
        step(1'b1, 32'hDEAD, 8'h5A, 1'b1, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b1, 32'hDEAD, 8'h5A, 1'b1, 1'b0, 1'b1);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst out_ctrl", out_ctrl, 8'h0);
        chk("rst count", count, 2'd0);
        chk("rst in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("in_ready after reset", in_ready, 1'b1);

        // Streaming 1..16
        rel_log.delete();
        for (int i = 1; i <= 16; i++) step(1'b1, i, 8'h01, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        chk("stream len", rel_log.size(), 16);
        for (int i = 0; i < rel_log.size() && i < 16; i++) chk("stream order", rel_log[i], i + 1);

        // Backpressure: A, B absorbed, C held upstream
        rel_log.delete();
        step(1'b1, 32'h11, 8'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 8'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33, 8'hA3, 1'b0, 1'b0, 1'b0);
        chk("bp count", count, 2'd2);
        chk("bp head", out_data, 32'h11);
        chk("bp head ctrl", out_ctrl, 8'hA1);
        chk("bp in_ready", in_ready, 1'b0);
        n = 0;
        do begin
            step(1'b1, 32'h33, 8'hA3, 1'b1, 1'b0, 1'b0);
            n++;
        end while (!mdl_acc && n < 10);
        chk("bp C accepted", mdl_acc, 1'b1);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        chk("bp release count", rel_log.size(), 3);
        if (rel_log.size() == 3) begin
            chk("bp order A", rel_log[0], 32'h11);
            chk("bp order B", rel_log[1], 32'h22);
            chk("bp order C", rel_log[2], 32'h33);
        end

        // Flush while full, D offered during flush
        step(1'b1, 32'h11, 8'hB1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 8'hB2, 1'b0, 1'b0, 1'b0);
        chk("pre-flush count", count, 2'd2);
        step(1'b1, 32'h44, 8'hC4, 1'b0, 1'b1, 1'b0);
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush out_ctrl", out_ctrl, 8'h0);
        chk("flush count", count, 2'd0);
        chk("flush data held", out_data, 32'h11);
        step(1'b1, 32'h44, 8'hC4, 1'b0, 1'b0, 1'b0);
        chk("D out_valid", out_valid, 1'b1);
        chk("D out_data", out_data, 32'h44);
        chk("D out_ctrl", out_ctrl, 8'hC4);

        // Simultaneous release and accept at count 1
        step(1'b1, 32'h55, 8'hC5, 1'b1, 1'b0, 1'b0);
        chk("swap out_data", out_data, 32'h55);
        chk("swap count", count, 2'd1);
        // Flush and reset together
        step(1'b1, 32'h66, 8'h06, 1'b1, 1'b1, 1'b1);
        chk("fr out_data", out_data, 32'h0);
        chk("fr count", count, 2'd0);
        chk("fr out_valid", out_valid, 1'b0);

        // Bubble control after release
        step(1'b1, 32'h77, 8'h77, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        chk("bubble out_valid", out_valid, 1'b0);
        chk("bubble out_ctrl", out_ctrl, 8'h0);
        chk("bubble data held", out_data, 32'h77);

        // Mixed traffic against the model
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, two-entry skid buffer and synchronous flush. It generalises the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block carrying a DATA_W payload and a CTRL_W control field. Control bits are forced to zero on any bubble, so an empty stage never asserts RegWrite or MemWrite. It sits between any two pipeline stages and supports stall (downstream backpressure) and flush (branch/exception squash) without losing or duplicating instructions.

## Interface
- DATA_W, 32: width of payload (ALU result, store data, dest reg, etc., concatenated by the instantiator)
- CTRL_W, 8: width of control field (RegWrite, MemWrite, MemToReg, ...); zeroed whenever the entry is invalid
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  synchronous, active-high; one clock and synchronous active-high reset are the fixed clocking scheme
- flush  input  1  squash all held entries this cycle
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- out_data  output  DATA_W  head payload (registered)
- out_ctrl  output  CTRL_W  head control (registered; 0 when out_valid=0)
- count  output  2  entries held: 0, 1 or 2

## Operation
- Storage: head register (drives out_*) and skid register; FIFO order, head is older.
- Accept: in_valid && in_ready. Release: out_valid && out_ready.
- in_ready = !skid_valid && !flush && !reset; only combinational term is flush/reset, otherwise a registered value.
- Next-state rules when no flush/reset:
  - count 0, accept: beat -> head.
  - count 1, release and accept: beat -> head.
  - count 1, accept, no release: beat -> skid (count 2).
  - count 1, release only: head empties, out_ctrl <- 0.
  - count 2, release: skid -> head, skid empties; no accept possible (in_ready=0).
  - count 2, no release: hold everything.
- flush: head and skid invalidated, out_ctrl and skid ctrl cleared, count <- 0; a beat presented that cycle is not accepted (in_ready=0). A release coinciding with flush still counts downstream (downstream sampled out_valid=1); entry is gone next cycle either way.
- Data fields of invalid entries are held (not cleared) except on reset; ctrl always cleared on invalidation.
- count = head_valid + skid_valid; skid_valid implies head_valid.

## Timing
- Reset values: out_valid 0, out_data 0, out_ctrl 0, count 0, internal skid cleared; in_ready 0 while reset high, 1 in first cycle after reset deasserts.
- reset takes priority over flush; flush over accept/release.
- Latency: beat accepted at edge N appears on out_* in cycle after edge N (one-cycle register latency).
- Throughput: 1 beat/cycle with out_ready held high; skid never fills.
- Backpressure: out_ready low for k cycles from count 1 -> one more beat absorbed, then in_ready low until a release; no beat dropped, no duplicate.
- out_data/out_ctrl stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all entries discarded same edge, identical to power-up state.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1, in_data=0xDEAD -> out_valid=0, out_data=0, out_ctrl=0, count=0, in_ready=0; cycle after release in_ready=1.
- Streaming: out_ready=1, feed data 1..16 ctrl 0x01 back-to-back -> out_data 1..16 each one cycle after accept, count never exceeds 1, in_ready stays 1.
- Backpressure: out_ready=0, offer A=0x11, B=0x22, C=0x33 -> A in head, B in skid, count=2, in_ready=0, C held upstream; raise out_ready -> outputs A, B, C in order, no gaps after skid drains.
- Flush full: count=2 (A,B), pulse flush with in_valid=1 D=0x44 -> next cycle out_valid=0, out_ctrl=0, count=0, D not accepted; D re-offered then appears next cycle.
- Simultaneous: count=1, out_ready=1 and in_valid=1 same cycle -> head replaced by new beat, count stays 1; flush+reset together -> reset values.
- Bubble control: after release with no new input, out_ctrl=0 while out_valid=0 even though out_data retains last payload.
